// File: rtl/heap_engine.sv
// Binary-heap priority queue serving PUSH/POP/TOP/SIZE commands; sifting moves one level per clock.
// Build option HEAP_ENGINE_MAX_HEAP_EN turns the min-heap into a max-heap.
module heap_engine #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    // state     | meaning
    // IDLE      | waiting for a command, cmd_ready high
    // SIFT_UP   | pushed entry climbing toward the root
    // SIFT_DOWN | relocated last entry sinking from the root
    // RESP      | rsp_valid pulse, then back to IDLE
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SIFT_UP   = 2'd1;
    localparam logic [1:0] SIFT_DOWN = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_TOP  = 2'b10;
    localparam logic [1:0] OP_SIZE = 2'b11;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Two spare bits so 2*idx+2 never wraps.
    localparam int IW = AW + 2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [DW-1:0] heap [DEPTH];
    logic [DW-1:0] res_data;
    logic          res_err;

    logic [IW-1:0] par, lc, rc, child, cnt_i;
    logic [DW-1:0] h_idx, h_par, h_lc, h_rc, h_ch;
    logic          lc_ok, rc_ok, pick_r, up_swap, dn_swap;
    logic          accept;

    function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef HEAP_ENGINE_MAX_HEAP_EN
        return a > b;
`else
        return a < b;
`endif
    endfunction

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        par     = (idx - IW'(1)) >> 1;
        lc      = {idx[IW-2:0], 1'b1};
        rc      = lc + IW'(1);
        cnt_i   = IW'(count);
        lc_ok   = lc < cnt_i;
        rc_ok   = rc < cnt_i;
        h_idx   = heap[AW'(idx)];
        h_par   = heap[AW'(par)];
        h_lc    = heap[AW'(lc)];
        h_rc    = heap[AW'(rc)];
        // Ties go left: the right child wins only when strictly better.
        pick_r  = rc_ok && better(h_rc, h_lc);
        child   = pick_r ? rc : lc;
        h_ch    = pick_r ? h_rc : h_lc;
        up_swap = (idx != '0) && better(h_idx, h_par);
        dn_swap = lc_ok && better(h_ch, h_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            idx      <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (full) begin
                                    rsp_data <= cmd_data;
                                    rsp_err  <= 1'b1;
                                    state    <= RESP;
                                end else begin
                                    res_data <= cmd_data;
                                    res_err  <= 1'b0;
                                    idx      <= IW'(count);
                                    count    <= count + CW'(1);
                                    state    <= SIFT_UP;
                                end
                            end
                            OP_POP: begin
                                if (empty) begin
                                    rsp_data <= '0;
                                    rsp_err  <= 1'b1;
                                    state    <= RESP;
                                end else begin
                                    res_data <= heap[0];
                                    res_err  <= 1'b0;
                                    idx      <= '0;
                                    count    <= count - CW'(1);
                                    state    <= SIFT_DOWN;
                                end
                            end
                            OP_TOP: begin
                                rsp_data <= empty ? '0 : heap[0];
                                rsp_err  <= empty;
                                state    <= RESP;
                            end
                            default: begin
                                rsp_data <= DW'(count);
                                rsp_err  <= 1'b0;
                                state    <= RESP;
                            end
                        endcase
                    end
                end
                SIFT_UP: begin
                    if (up_swap) begin
                        idx <= par;
                    end else begin
                        rsp_data <= res_data;
                        rsp_err  <= res_err;
                        state    <= RESP;
                    end
                end
                SIFT_DOWN: begin
                    if (dn_swap) begin
                        idx <= child;
                    end else begin
                        rsp_data <= res_data;
                        rsp_err  <= res_err;
                        state    <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage carries no reset; contents are meaningless whenever count says so.
    always_ff @(posedge clk) begin
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (accept && cmd_op == OP_PUSH && !full)
                        heap[AW'(count)] <= cmd_data;
                    else if (accept && cmd_op == OP_POP && !empty)
                        heap[0] <= heap[AW'(count - CW'(1))];
                end
                SIFT_UP: begin
                    if (up_swap) begin
                        heap[AW'(idx)] <= h_par;
                        heap[AW'(par)] <= h_idx;
                    end
                end
                SIFT_DOWN: begin
                    if (dn_swap) begin
                        heap[AW'(idx)]   <= h_ch;
                        heap[AW'(child)] <= h_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_engine.sv
// Self-checking bench for heap_engine: random and directed commands against a queue-based priority model.
module tb_heap_engine;

    localparam int DEPTH   = 16;
    localparam int MAX_LAT = 2 + 4;
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_TOP  = 2'b10;
    localparam logic [1:0] OP_SIZE = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];

    heap_engine #(.DEPTH(DEPTH), .DW(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference: unordered queue; the priority element is found by a linear scan.
    function automatic int best_pos();
        int b = 0;
        for (int i = 1; i < q.size(); i++) begin
`ifdef HEAP_ENGINE_MAX_HEAP_EN
            if (q[i] > q[b]) b = i;
`else
            if (q[i] < q[b]) b = i;
`endif
        end
        return b;
    endfunction

    task automatic model_op(input logic [1:0] op, input logic [7:0] d,
                            output logic [7:0] ed, output logic ee, output int ecnt);
        int b;
        ed = 8'h00;
        ee = 1'b0;
        case (op)
            OP_PUSH: begin
                ed = d;
                if (q.size() == DEPTH) ee = 1'b1;
                else q.push_back(d);
            end
            OP_POP: begin
                if (q.size() == 0) ee = 1'b1;
                else begin
                    b = best_pos();
                    ed = q[b];
                    q.delete(b);
                end
            end
            OP_TOP: begin
                if (q.size() == 0) ee = 1'b1;
                else ed = q[best_pos()];
            end
            default: ed = 8'(q.size());
        endcase
        ecnt = q.size();
    endtask

    // Issues one command and measures acceptance-to-response latency.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d,
                          output logic [7:0] rd, output logic re, output int lat,
                          output int cnt1, output logic f1, output logic e1);
        int  w = 0;
        logic got = 1'b0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
        lat = 0; cnt1 = -1; f1 = 1'b0; e1 = 1'b0; rd = 8'h00; re = 1'b0;
        while (lat < 40 && !got) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                cnt1 = int'(count);
                f1 = full;
                e1 = empty;
            end
            if (rsp_valid) begin
                rd = rsp_data;
                re = rsp_err;
                got = 1'b1;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: op=%0d no rsp_valid within %0d cycles", op, lat);
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd; logic re, f1, e1; int lat, c1;
        total++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_err, empty, full, count} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0}) begin
            bad++;
            $display("FAIL reset_values: rdy=%b vld=%b data=%h err=%b empty=%b full=%b count=%0d", cmd_ready, rsp_valid, rsp_data, rsp_err, empty, full, count);
        end
        do_cmd(OP_SIZE, 8'h00, rd, re, lat, c1, f1, e1);
        total++;
        if (lat !== 1 || rd !== 8'h00 || re !== 1'b0) begin
            bad++;
            $display("FAIL reset_size: lat=%0d data=%h err=%b required lat=1 data=00 err=0", lat, rd, re);
        end
    endtask

    task automatic test_basic();
        logic [1:0] ops [6]  = '{OP_PUSH, OP_PUSH, OP_SIZE, OP_TOP, OP_POP, OP_SIZE};
        logic [7:0] dats [6] = '{8'h07, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] rd, ed; logic re, ee, f1, e1; int lat, c1, ec;
        for (int i = 0; i < 7; i++) begin
            logic [1:0] op = (i == 6) ? OP_TOP : ops[i];
            logic [7:0] d  = (i == 6) ? 8'h00 : dats[i];
            do_cmd(op, d, rd, re, lat, c1, f1, e1);
            model_op(op, d, ed, ee, ec);
            total++;
            if (re !== ee || rd !== ed || c1 != ec) begin
                bad++;
                $display("FAIL basic_%0d: data=%h err=%b count=%0d required data=%h err=%b count=%0d", i, rd, re, c1, ed, ee, ec);
            end
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== ed || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL rsp_hold: vld=%b data=%h err=%b required vld=0 data=%h err=0", rsp_valid, rsp_data, rsp_err, ed);
        end
    endtask

    task automatic test_empty_err();
        logic [7:0] rd, ed; logic re, ee, f1, e1; int lat, c1, ec;
        while (q.size() > 0) begin
            do_cmd(OP_POP, 8'h00, rd, re, lat, c1, f1, e1);
            model_op(OP_POP, 8'h00, ed, ee, ec);
        end
        for (int i = 0; i < 2; i++) begin
            logic [1:0] op = (i == 0) ? OP_POP : OP_TOP;
            do_cmd(op, 8'h00, rd, re, lat, c1, f1, e1);
            model_op(op, 8'h00, ed, ee, ec);
            total++;
            if (re !== 1'b1 || c1 != 0 || lat != 1 || e1 !== 1'b1) begin
                bad++;
                $display("FAIL empty_err_%0d: err=%b count=%0d lat=%0d empty=%b required err=1 count=0 lat=1 empty=1", i, re, c1, lat, e1);
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] rd, ed; logic re, ee, f1, e1; int lat, c1, ec;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d = 8'($urandom);
            do_cmd(OP_PUSH, d, rd, re, lat, c1, f1, e1);
            model_op(OP_PUSH, d, ed, ee, ec);
        end
        do_cmd(OP_PUSH, 8'h55, rd, re, lat, c1, f1, e1);
        model_op(OP_PUSH, 8'h55, ed, ee, ec);
        total++;
        if (re !== 1'b1 || c1 != DEPTH || f1 !== 1'b1 || lat != 1 || rd !== 8'h55) begin
            bad++;
            $display("FAIL full_push: err=%b count=%0d full=%b lat=%0d data=%h required err=1 count=16 full=1 lat=1 data=55", re, c1, f1, lat, rd);
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_cmd(OP_POP, 8'h00, rd, re, lat, c1, f1, e1);
            model_op(OP_POP, 8'h00, ed, ee, ec);
            total++;
            if (re !== 1'b0 || rd !== ed || c1 != ec) begin
                bad++;
                $display("FAIL full_drain_%0d: data=%h err=%b count=%0d required data=%h err=0 count=%0d", i, rd, re, c1, ed, ec);
            end
        end
    endtask

    task automatic test_sorted();
        logic [7:0] seed [6] = '{8'hF0, 8'h10, 8'h10, 8'h03, 8'hFF, 8'h00};
        logic [7:0] rd, ed, prev; logic re, ee, f1, e1; int lat, c1, ec;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d = (i < 6) ? seed[i] : 8'(8'hE0 - (i - 6) * 8'h11);
            do_cmd(OP_PUSH, d, rd, re, lat, c1, f1, e1);
            model_op(OP_PUSH, d, ed, ee, ec);
            total++;
            if (re !== 1'b0 || lat < 2 || lat > MAX_LAT || c1 != ec) begin
                bad++;
                $display("FAIL sorted_push_%0d: err=%b lat=%0d count=%0d required err=0 lat=2..%0d count=%0d", i, re, lat, c1, MAX_LAT, ec);
            end
        end
`ifdef HEAP_ENGINE_MAX_HEAP_EN
        prev = 8'hFF;
`else
        prev = 8'h00;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            do_cmd(OP_POP, 8'h00, rd, re, lat, c1, f1, e1);
            model_op(OP_POP, 8'h00, ed, ee, ec);
            total++;
`ifdef HEAP_ENGINE_MAX_HEAP_EN
            if (rd !== ed || re !== 1'b0 || rd > prev || lat < 2 || lat > MAX_LAT) begin
`else
            if (rd !== ed || re !== 1'b0 || rd < prev || lat < 2 || lat > MAX_LAT) begin
`endif
                bad++;
                $display("FAIL sorted_pop_%0d: data=%h err=%b lat=%0d required data=%h err=0 lat=2..%0d", i, rd, re, lat, ed, MAX_LAT);
            end
            prev = rd;
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, ed; logic re, ee, f1, e1; int lat, c1, ec;
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            logic [7:0] d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            int exp_lo, exp_hi;
            do_cmd(op, d, rd, re, lat, c1, f1, e1);
            model_op(op, d, ed, ee, ec);
            exp_lo = (ee || op == OP_TOP || op == OP_SIZE) ? 1 : 2;
            exp_hi = (exp_lo == 1) ? 1 : MAX_LAT;
            total++;
            if (re !== ee || (!ee && rd !== ed) || c1 != ec || f1 !== (ec == DEPTH) || e1 !== (ec == 0)
                || lat < exp_lo || lat > exp_hi) begin
                bad++;
                $display("FAIL random_%0d op=%0d: data=%h err=%b count=%0d lat=%0d required data=%h err=%b count=%0d lat=%0d..%0d",
                         i, op, rd, re, c1, lat, ed, ee, ec, exp_lo, exp_hi);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd, ed; logic re, ee, f1, e1; int lat, c1, ec;
        int seen = 0;
        while (q.size() > 0) begin
            do_cmd(OP_POP, 8'h00, rd, re, lat, c1, f1, e1);
            model_op(OP_POP, 8'h00, ed, ee, ec);
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d = 8'(8'h80 - i * 8'h0F);
            do_cmd(OP_PUSH, d, rd, re, lat, c1, f1, e1);
            model_op(OP_PUSH, d, ed, ee, ec);
        end
        @(negedge clk);
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_POP;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        if (rsp_valid) seen++;
        total++;
        if (count !== 5'd0 || cmd_ready !== 1'b1 || empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: count=%0d rdy=%b empty=%b required count=0 rdy=1 empty=1", count, cmd_ready, empty);
        end
        reset = 1'b0;
        q.delete();
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_rsp: rsp_valid pulses=%0d required 0", seen);
        end
        do_cmd(OP_SIZE, 8'h00, rd, re, lat, c1, f1, e1);
        total++;
        if (rd !== 8'h00 || re !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_size: data=%h err=%b required data=00 err=0", rd, re);
        end
    endtask

`ifdef HEAP_ENGINE_MAX_HEAP_EN
    task automatic test_max_heap();
        logic [7:0] want [4] = '{8'h09, 8'h09, 8'h07, 8'h04};
        logic [7:0] rd; logic re, f1, e1; int lat, c1;
        logic [7:0] ed; logic ee; int ec;
        logic [7:0] pushes [3] = '{8'h07, 8'h04, 8'h09};
        for (int i = 0; i < 3; i++) begin
            do_cmd(OP_PUSH, pushes[i], rd, re, lat, c1, f1, e1);
            model_op(OP_PUSH, pushes[i], ed, ee, ec);
        end
        for (int i = 0; i < 4; i++) begin
            logic [1:0] op = (i == 0) ? OP_TOP : OP_POP;
            do_cmd(op, 8'h00, rd, re, lat, c1, f1, e1);
            model_op(op, 8'h00, ed, ee, ec);
            total++;
            if (rd !== want[i] || re !== 1'b0) begin
                bad++;
                $display("FAIL max_heap_%0d: data=%h err=%b required data=%h err=0", i, rd, re, want[i]);
            end
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_empty_err();
        test_full();
        test_sorted();
        test_random();
        test_reset_mid();
`ifdef HEAP_ENGINE_MAX_HEAP_EN
        test_max_heap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
